video_timing_gen: RTL and testbench
===================================

VIDEO_TIMING_GEN -- requirements
Module: video_timing_gen

Interface
REQ-001 SHALL provide parameters (name, default, meaning), one per line:
- H_DISPLAY, 640, visible pixels per line
- H_FRONT, 16, horizontal front porch
- H_SYNC, 96, hsync width
- H_BACK, 48, horizontal back porch
- V_DISPLAY, 480, visible lines
- V_FRONT, 10, vertical front porch
- V_SYNC, 2, vsync width
- V_BACK, 33, vertical back porch
- HSYNC_ACTIVE, 0, hsync asserted level
- VSYNC_ACTIVE, 0, vsync asserted level
- H_W, 10, hpos width
- V_W, 10, vpos width
- FRAME_W, 8, frame counter width
REQ-002 SHALL provide ports (name, direction, width, meaning), one per line:
- clk  in  1  clock
- reset  in  1  asynchronous, active-low reset
- ce  in  1  pixel-clock enable; counters advance only on edges where ce=1
- restart  in  1  synchronous frame restart
- hpos  out  H_W  current pixel column
- vpos  out  V_W  current line
- hsync  out  1  horizontal sync at HSYNC_ACTIVE polarity
- vsync  out  1  vertical sync at VSYNC_ACTIVE polarity
- display_on  out  1  current position is visible
- line_start  out  1  one-clk pulse when hpos becomes 0
- frame_start  out  1  one-clk pulse when (hpos,vpos) becomes (0,0)
- frame_count  out  FRAME_W  completed-frame counter

Function
REQ-003 SHALL define H_TOTAL=H_DISPLAY+H_FRONT+H_SYNC+H_BACK and V_TOTAL likewise; hpos counts 0..H_TOTAL-1, vpos counts 0..V_TOTAL-1.
REQ-004 SHALL register all outputs, with hsync, vsync, display_on and pulses coherent with hpos/vpos in the same cycle; no one-cycle sync lag.
REQ-005 SHALL assert hsync iff H_DISPLAY+H_FRONT <= hpos < H_DISPLAY+H_FRONT+H_SYNC; vsync iff V_DISPLAY+V_FRONT <= vpos < V_DISPLAY+V_FRONT+V_SYNC.
REQ-006 SHALL assert display_on iff hpos<H_DISPLAY and vpos<V_DISPLAY.
REQ-007 On a ce edge, SHALL increment hpos; at hpos=H_TOTAL-1, hpos wraps to 0 and vpos increments; at vpos=V_TOTAL-1 also, vpos wraps to 0.
REQ-008 With ce=0, SHALL hold hpos, vpos, syncs, display_on and frame_count; line_start/frame_start SHALL be 0.
REQ-009 line_start SHALL be high for exactly one clk following the edge on which hpos was loaded with 0; frame_start likewise for (0,0). Both pulse together at frame start.
REQ-010 frame_count SHALL increment (modulo 2^FRAME_W) on every frame_start caused by natural wrap.
REQ-011 restart=1 at an edge SHALL load hpos=0 and vpos=0, pulse line_start and frame_start, and clear frame_count to 0, regardless of ce; restart has priority over wrap and ce.
REQ-012 Held restart SHALL keep the position at (0,0) and the pulses high each clk until released.

Reset
REQ-013 reset=0 SHALL immediately set hpos=H_TOTAL-1, vpos=V_TOTAL-1, display_on=0, hsync=~HSYNC_ACTIVE, vsync=~VSYNC_ACTIVE, line_start=0, frame_start=0, frame_count=0.
REQ-014 The first ce edge after reset release SHALL enter (0,0), pulse frame_start and line_start, and leave frame_count at 0 (no increment for the post-reset entry).
REQ-015 Reset asserted mid-frame SHALL take effect without a clock edge and override restart and ce.

Verification
REQ-016 Reset, then ce=1 continuously for 800 clks -> first edge: (0,0) with frame_start=1 and display_on=1; hpos=656..751 with hsync=0; hpos=640 with display_on=0.
REQ-017 Run 420000 ce=1 clks -> frame_start exactly once per 420000 clks; vsync low on vpos 490..491 only; frame_count=1 after the second frame start.
REQ-018 ce pulsed every 4th clk -> hpos advances once per 4 clks; pulses last 1 clk, not 4.
REQ-019 restart=1 at hpos=300, vpos=200 -> next cycle: (0,0), line_start=frame_start=1, frame_count=0.
REQ-020 restart coincident with the (H_TOTAL-1, V_TOTAL-1) wrap -> single (0,0) entry, frame_count=0, no increment.
REQ-021 HSYNC_ACTIVE=1, H_DISPLAY=256, H_FRONT=8, H_SYNC=24, H_BACK=24 -> hsync high for hpos 264..287; line period 312 ce edges.

Source files
------------

// File: rtl/video_timing_gen.sv
// Raster timing generator: pixel/line counters with registered sync, blanking and
// frame markers, all decoded from the next position so they line up with hpos/vpos.
module video_timing_gen #(
  parameter int   H_DISPLAY    = 640,
  parameter int   H_FRONT      = 16,
  parameter int   H_SYNC       = 96,
  parameter int   H_BACK       = 48,
  parameter int   V_DISPLAY    = 480,
  parameter int   V_FRONT      = 10,
  parameter int   V_SYNC       = 2,
  parameter int   V_BACK       = 33,
  parameter logic HSYNC_ACTIVE = 1'b0,
  parameter logic VSYNC_ACTIVE = 1'b0,
  parameter int   H_W          = 10,
  parameter int   V_W          = 10,
  parameter int   FRAME_W      = 8
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               ce,
  input  logic               restart,
  output logic [H_W-1:0]     hpos,
  output logic [V_W-1:0]     vpos,
  output logic               hsync,
  output logic               vsync,
  output logic               display_on,
  output logic               line_start,
  output logic               frame_start,
  output logic [FRAME_W-1:0] frame_count
);

  localparam int H_TOTAL = H_DISPLAY + H_FRONT + H_SYNC + H_BACK;
  localparam int V_TOTAL = V_DISPLAY + V_FRONT + V_SYNC + V_BACK;

  localparam logic [H_W-1:0] H_LAST       = H_W'(H_TOTAL - 1);
  localparam logic [H_W-1:0] H_DISP_END   = H_W'(H_DISPLAY);
  localparam logic [H_W-1:0] H_SYNC_START = H_W'(H_DISPLAY + H_FRONT);
  localparam logic [H_W-1:0] H_SYNC_END   = H_W'(H_DISPLAY + H_FRONT + H_SYNC);
  localparam logic [V_W-1:0] V_LAST       = V_W'(V_TOTAL - 1);
  localparam logic [V_W-1:0] V_DISP_END   = V_W'(V_DISPLAY);
  localparam logic [V_W-1:0] V_SYNC_START = V_W'(V_DISPLAY + V_FRONT);
  localparam logic [V_W-1:0] V_SYNC_END   = V_W'(V_DISPLAY + V_FRONT + V_SYNC);

  logic [H_W-1:0]     hpos_next;
  logic [V_W-1:0]     vpos_next;
  logic [FRAME_W-1:0] count_next;
  logic               line_next;
  logic               frame_next;
  logic               hsync_next;
  logic               vsync_next;
  logic               display_next;
  // Set by reset so the first wrap into (0,0) is not counted as a completed frame.
  logic               first_reg;
  logic               first_next;

  always_comb begin
    hpos_next  = hpos;
    vpos_next  = vpos;
    count_next = frame_count;
    first_next = first_reg;
    line_next  = 1'b0;
    frame_next = 1'b0;
    if (restart) begin
      hpos_next  = '0;
      vpos_next  = '0;
      line_next  = 1'b1;
      frame_next = 1'b1;
      count_next = '0;
      first_next = 1'b0;
    end else if (ce) begin
      if (hpos == H_LAST) begin
        hpos_next = '0;
        line_next = 1'b1;
        if (vpos == V_LAST) begin
          vpos_next  = '0;
          frame_next = 1'b1;
          if (first_reg) begin
            first_next = 1'b0;
          end else begin
            count_next = frame_count + FRAME_W'(1);
          end
        end else begin
          vpos_next = vpos + V_W'(1);
        end
      end else begin
        hpos_next = hpos + H_W'(1);
      end
    end
  end

  always_comb begin
    hsync_next   = ((hpos_next >= H_SYNC_START) && (hpos_next < H_SYNC_END)) ?
                   HSYNC_ACTIVE : ~HSYNC_ACTIVE;
    vsync_next   = ((vpos_next >= V_SYNC_START) && (vpos_next < V_SYNC_END)) ?
                   VSYNC_ACTIVE : ~VSYNC_ACTIVE;
    display_next = (hpos_next < H_DISP_END) && (vpos_next < V_DISP_END);
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      hpos        <= H_LAST;
      vpos        <= V_LAST;
      hsync       <= ~HSYNC_ACTIVE;
      vsync       <= ~VSYNC_ACTIVE;
      display_on  <= 1'b0;
      line_start  <= 1'b0;
      frame_start <= 1'b0;
      frame_count <= '0;
      first_reg   <= 1'b1;
    end else begin
      hpos        <= hpos_next;
      vpos        <= vpos_next;
      hsync       <= hsync_next;
      vsync       <= vsync_next;
      display_on  <= display_next;
      line_start  <= line_next;
      frame_start <= frame_next;
      frame_count <= count_next;
      first_reg   <= first_next;
    end
  end

endmodule

// File: tb/tb_video_timing_gen.sv
// Bench: default-timing instance checked against a hand-computed table, and a small
// raster instance (312x10, active-high hsync, 2-bit frame counter) checked every clock.
module tb_video_timing_gen;

  localparam int B_HT = 312;
  localparam int B_VT = 10;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic reset, ce, restart;

  logic [9:0] a_hpos, a_vpos;
  logic       a_hsync, a_vsync, a_display_on, a_line_start, a_frame_start;
  logic [7:0] a_frame_count;

  logic [9:0] b_hpos, b_vpos;
  logic       b_hsync, b_vsync, b_display_on, b_line_start, b_frame_start;
  logic [1:0] b_frame_count;

  video_timing_gen dut_a (
    .clk(clk), .reset(reset), .ce(ce), .restart(restart),
    .hpos(a_hpos), .vpos(a_vpos), .hsync(a_hsync), .vsync(a_vsync),
    .display_on(a_display_on), .line_start(a_line_start),
    .frame_start(a_frame_start), .frame_count(a_frame_count)
  );

  video_timing_gen #(
    .H_DISPLAY(256), .H_FRONT(8), .H_SYNC(24), .H_BACK(24),
    .V_DISPLAY(4), .V_FRONT(2), .V_SYNC(2), .V_BACK(2),
    .HSYNC_ACTIVE(1'b1), .FRAME_W(2)
  ) dut_b (
    .clk(clk), .reset(reset), .ce(ce), .restart(restart),
    .hpos(b_hpos), .vpos(b_vpos), .hsync(b_hsync), .vsync(b_vsync),
    .display_on(b_display_on), .line_start(b_line_start),
    .frame_start(b_frame_start), .frame_count(b_frame_count)
  );

  int compared   = 0;
  int mismatched = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    compared++;
    if (act !== exp) begin
      mismatched++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Reference model of the small raster
  int mh, mv, mcnt;
  bit mls, mfs, mfirst;

  task automatic model_reset();
    mh = B_HT - 1; mv = B_VT - 1; mls = 0; mfs = 0; mcnt = 0; mfirst = 1;
  endtask

  task automatic model_edge(input bit c, input bit r);
    if (r) begin
      mh = 0; mv = 0; mls = 1; mfs = 1; mcnt = 0; mfirst = 0;
    end else if (c) begin
      mls = 0; mfs = 0;
      if (mh == B_HT - 1) begin
        mh = 0; mls = 1;
        if (mv == B_VT - 1) begin
          mv = 0; mfs = 1;
          if (mfirst) mfirst = 0;
          else mcnt = (mcnt + 1) % 4;
        end else mv++;
      end else mh++;
    end else begin
      mls = 0; mfs = 0;
    end
  endtask

  function automatic logic [63:0] b_exp();
    logic hs, vs, de;
    hs = (mh >= 264) && (mh < 288);
    vs = !((mv >= 6) && (mv < 8));
    de = (mh < 256) && (mv < 4);
    return 64'({10'(mh), 10'(mv), hs, vs, de, mls, mfs, 2'(mcnt)});
  endfunction

  function automatic logic [63:0] b_act();
    return 64'({b_hpos, b_vpos, b_hsync, b_vsync, b_display_on, b_line_start,
                b_frame_start, b_frame_count});
  endfunction

  function automatic logic [63:0] a_act();
    return 64'({a_hpos, a_vpos, a_hsync, a_vsync, a_display_on, a_line_start,
                a_frame_start, a_frame_count});
  endfunction

  task automatic step(input bit c, input bit r);
    ce = c; restart = r;
    @(posedge clk);
    #1;
    if (reset) model_edge(c, r);
    else model_reset();
    check("b_state", b_act(), b_exp());
  endtask

  task automatic run_to(input int h, input int v);
    int n = 0;
    while (!(mh == h && mv == v) && n < 4000) begin
      step(1'b1, 1'b0);
      n++;
    end
    check("run_to_pos", 64'({b_hpos, b_vpos}), 64'({10'(h), 10'(v)}));
  endtask

  typedef struct {
    int   e;
    int   h;
    int   v;
    logic hs;
    logic de;
    logic ls;
    logic fs;
  } vec_t;

  vec_t tbl[11];

  initial begin
    int fs_seen, last_fs, ls_seen;

    tbl[0]  = '{1,   0,   0, 1'b1, 1'b1, 1'b1, 1'b1};
    tbl[1]  = '{2,   1,   0, 1'b1, 1'b1, 1'b0, 1'b0};
    tbl[2]  = '{640, 639, 0, 1'b1, 1'b1, 1'b0, 1'b0};
    tbl[3]  = '{641, 640, 0, 1'b1, 1'b0, 1'b0, 1'b0};
    tbl[4]  = '{656, 655, 0, 1'b1, 1'b0, 1'b0, 1'b0};
    tbl[5]  = '{657, 656, 0, 1'b0, 1'b0, 1'b0, 1'b0};
    tbl[6]  = '{700, 699, 0, 1'b0, 1'b0, 1'b0, 1'b0};
    tbl[7]  = '{752, 751, 0, 1'b0, 1'b0, 1'b0, 1'b0};
    tbl[8]  = '{753, 752, 0, 1'b1, 1'b0, 1'b0, 1'b0};
    tbl[9]  = '{800, 799, 0, 1'b1, 1'b0, 1'b0, 1'b0};
    tbl[10] = '{801, 0,   1, 1'b1, 1'b1, 1'b1, 1'b0};

    // Reset held with ce and restart both asserted: reset must win
    reset = 1'b1; ce = 1'b1; restart = 1'b1;
    model_reset();
    #2 reset = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("a_reset", a_act(), 64'({10'd799, 10'd524, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 8'd0}));
    check("b_reset", b_act(), b_exp());

    // Continuous ce: table for the default raster, model for the small one
    reset = 1'b1;
    fs_seen = 0; last_fs = 0;
    for (int e = 1; e <= 4 * B_HT * B_VT + 1; e++) begin
      step(1'b1, 1'b0);
      for (int i = 0; i < 11; i++) begin
        if (tbl[i].e == e)
          check($sformatf("a_vec_e%0d", e), a_act(),
                64'({10'(tbl[i].h), 10'(tbl[i].v), tbl[i].hs, 1'b1, tbl[i].de,
                     tbl[i].ls, tbl[i].fs, 8'd0}));
      end
      if (b_frame_start) begin
        fs_seen++;
        if (fs_seen > 1) check("fs_interval", 64'(e - last_fs), 64'(B_HT * B_VT));
        if (fs_seen == 2) check("count_after_2nd", 64'(b_frame_count), 64'd1);
        last_fs = e;
      end
    end
    check("fs_total", 64'(fs_seen), 64'd5);
    check("count_wrapped", 64'(b_frame_count), 64'd0);

    // ce every 4th clock: positions hold, pulses last one clock
    ls_seen = 0;
    for (int k = 0; k < 320; k++) begin
      step(1'b1, 1'b0);
      if (b_line_start) ls_seen++;
      if (k == 0) check("a_ce4_adv0", 64'(a_hpos), 64'd481);
      if (k == 1) check("a_ce4_adv1", 64'(a_hpos), 64'd482);
      for (int j = 0; j < 3; j++) begin
        step(1'b0, 1'b0);
        if (b_line_start) ls_seen++;
      end
      if (k == 0) check("a_ce4_hold", 64'({a_hpos, a_line_start}), 64'({10'd481, 1'b0}));
    end
    check("ls_clks", 64'(ls_seen), 64'd1);

    // Mid-frame restart, then held restart with ce low
    run_to(300, 5);
    step(1'b1, 1'b1);
    check("b_restart", b_act(), 64'({10'd0, 10'd0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 2'd0}));
    check("a_restart", 64'({a_hpos, a_vpos, a_line_start, a_frame_start, a_frame_count}),
          64'({10'd0, 10'd0, 1'b1, 1'b1, 8'd0}));
    for (int j = 0; j < 3; j++) begin
      step(1'b0, 1'b1);
      check("b_restart_held", 64'({b_hpos, b_vpos, b_line_start, b_frame_start}),
            64'({10'd0, 10'd0, 1'b1, 1'b1}));
    end
    step(1'b1, 1'b0);
    check("b_restart_release", 64'({b_hpos, b_frame_start}), 64'({10'd1, 1'b0}));

    // Natural wrap counts, then restart coincident with the wrap clears it
    run_to(B_HT - 1, B_VT - 1);
    step(1'b1, 1'b0);
    check("count_after_wrap", 64'({b_frame_start, b_frame_count}), 64'({1'b1, 2'd1}));
    step(1'b1, 1'b0);
    run_to(B_HT - 1, B_VT - 1);
    step(1'b1, 1'b1);
    check("restart_at_wrap", 64'({b_hpos, b_vpos, b_frame_start, b_frame_count}),
          64'({10'd0, 10'd0, 1'b1, 2'd0}));
    step(1'b1, 1'b0);
    check("after_restart_wrap", 64'({b_hpos, b_frame_start, b_frame_count}),
          64'({10'd1, 1'b0, 2'd0}));

    // Asynchronous reset mid-frame, no clock edge needed
    repeat (5) step(1'b1, 1'b0);
    ce = 1'b1; restart = 1'b1;
    #2 reset = 1'b0;
    #1;
    model_reset();
    check("b_async_reset", b_act(), b_exp());
    check("a_async_reset", 64'({a_hpos, a_vpos, a_display_on}), 64'({10'd799, 10'd524, 1'b0}));
    step(1'b1, 1'b1);
    step(1'b1, 1'b1);
    reset = 1'b1;
    step(1'b1, 1'b0);
    check("b_post_reset_entry", 64'({b_hpos, b_vpos, b_frame_start, b_line_start, b_frame_count}),
          64'({10'd0, 10'd0, 1'b1, 1'b1, 2'd0}));
    check("a_post_reset_entry", 64'({a_hpos, a_vpos, a_frame_start, a_display_on, a_frame_count}),
          64'({10'd0, 10'd0, 1'b1, 1'b1, 8'd0}));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
